// File: rtl/rs_issue_queue.sv
// ALU reservation station: CDB wakeup, single-issue select into a one-entry skid register.
// Optional AGE_SELECT_EN macro selects oldest-first issue via an age matrix.
module rs_issue_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 32,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [DATA_W-1:0] disp_pc,
  input  logic [IMM_W-1:0]  disp_imm,
  input  logic [TAG_W-1:0]  disp_rob_id,
  input  logic              disp_rs1_rdy,
  input  logic [DATA_W-1:0] disp_rs1_val,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic              disp_rs2_rdy,
  input  logic [DATA_W-1:0] disp_rs2_val,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  output logic              rs_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_pc,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  output logic [IMM_W-1:0]  alu_imm,
  output logic [TAG_W-1:0]  alu_rob_id
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic [TAG_W-1:0]  rob_id;
    logic              rs1_rdy;
    logic [DATA_W-1:0] rs1_val;
    logic [TAG_W-1:0]  rs1_tag;
    logic              rs2_rdy;
    logic [DATA_W-1:0] rs2_val;
    logic [TAG_W-1:0]  rs2_tag;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic [TAG_W-1:0]  rob_id;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
  } issue_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  issue_t           iss_q, iss_d;
  logic             alu_valid_q, alu_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] elig;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_found;
  logic [IDX_W-1:0] disp_idx;
  logic             disp_accept;
  logic             issue_load;
  entry_t           disp_ent;

  assign rs_full     = (count_q == CNT_W'(DEPTH));
  assign disp_accept = disp_valid & ~rs_full & disp_found;
  assign issue_load  = (~alu_valid_q | alu_ready) & sel_found;

  always_comb begin
    elig       = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      elig[i] = ent_q[i].valid & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
      // Descending scan: the last hit is the lowest free index.
      if (!ent_q[i].valid) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

`ifdef AGE_SELECT_EN
  // age_q[j][i] set means entry j is older than entry i.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  always_comb begin
    logic [DEPTH-1:0] older;
    sel_found = |elig;
    sel_idx   = '0;
    older     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older[j] = age_q[j][i];
      end
      if (elig[i] && ((older & elig) == '0)) begin
        sel_idx = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    sel_found = |elig;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    disp_ent         = '0;
    disp_ent.valid   = 1'b1;
    disp_ent.op      = disp_op;
    disp_ent.pc      = disp_pc;
    disp_ent.imm     = disp_imm;
    disp_ent.rob_id  = disp_rob_id;
    disp_ent.rs1_tag = disp_rs1_tag;
    disp_ent.rs2_tag = disp_rs2_tag;
    disp_ent.rs1_rdy = disp_rs1_rdy;
    disp_ent.rs1_val = disp_rs1_val;
    disp_ent.rs2_rdy = disp_rs2_rdy;
    disp_ent.rs2_val = disp_rs2_val;
    // Result broadcast in the dispatch cycle would otherwise be missed.
    if (!disp_rs1_rdy && cdb_valid && (cdb_tag == disp_rs1_tag)) begin
      disp_ent.rs1_rdy = 1'b1;
      disp_ent.rs1_val = cdb_value;
    end
    if (!disp_rs2_rdy && cdb_valid && (cdb_tag == disp_rs2_tag)) begin
      disp_ent.rs2_rdy = 1'b1;
      disp_ent.rs2_val = cdb_value;
    end
  end

  always_comb begin
    ent_d       = ent_q;
    iss_d       = iss_q;
    alu_valid_d = alu_valid_q;
    count_d     = count_q;
`ifdef AGE_SELECT_EN
    age_d       = age_q;
`endif
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
`ifdef AGE_SELECT_EN
        age_d[i] = '0;
`endif
      end
      alu_valid_d = 1'b0;
      count_d     = '0;
    end else begin
      if (~alu_valid_q | alu_ready) begin
        alu_valid_d = sel_found;
      end
      if (issue_load) begin
        iss_d.op     = ent_q[sel_idx].op;
        iss_d.pc     = ent_q[sel_idx].pc;
        iss_d.imm    = ent_q[sel_idx].imm;
        iss_d.rob_id = ent_q[sel_idx].rob_id;
        iss_d.rs1    = ent_q[sel_idx].rs1_val;
        iss_d.rs2    = ent_q[sel_idx].rs2_val;
        ent_d[sel_idx].valid = 1'b0;
`ifdef AGE_SELECT_EN
        for (int j = 0; j < DEPTH; j++) begin
          age_d[sel_idx][j] = 1'b0;
          age_d[j][sel_idx] = 1'b0;
        end
`endif
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && cdb_valid) begin
          if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_tag)) begin
            ent_d[i].rs1_rdy = 1'b1;
            ent_d[i].rs1_val = cdb_value;
          end
          if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_tag)) begin
            ent_d[i].rs2_rdy = 1'b1;
            ent_d[i].rs2_val = cdb_value;
          end
        end
      end
      if (disp_accept) begin
`ifdef AGE_SELECT_EN
        // Every entry surviving this edge is older than the newcomer.
        for (int j = 0; j < DEPTH; j++) begin
          age_d[j][disp_idx] = ent_d[j].valid;
          age_d[disp_idx][j] = 1'b0;
        end
`endif
        ent_d[disp_idx] = disp_ent;
      end
      count_d = count_q + CNT_W'(disp_accept) - CNT_W'(issue_load);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
`ifdef AGE_SELECT_EN
        age_q[i] <= '0;
`endif
      end
      iss_q       <= '0;
      alu_valid_q <= 1'b0;
      count_q     <= '0;
    end else if (rdy) begin
      ent_q       <= ent_d;
      iss_q       <= iss_d;
      alu_valid_q <= alu_valid_d;
      count_q     <= count_d;
`ifdef AGE_SELECT_EN
      age_q       <= age_d;
`endif
    end
  end

  assign alu_valid  = alu_valid_q;
  assign alu_op     = iss_q.op;
  assign alu_pc     = iss_q.pc;
  assign alu_rs1    = iss_q.rs1;
  assign alu_rs2    = iss_q.rs2;
  assign alu_imm    = iss_q.imm;
  assign alu_rob_id = iss_q.rob_id;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Self-checking bench for rs_issue_queue: vector table, directed corner sequences,
// and randomized traffic against an entry-array reference model with dispatch sequence numbers.
module tb_rs_issue_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1, flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic [5:0]  disp_op = '0;
  logic [31:0] disp_pc = '0, disp_imm = '0;
  logic [3:0]  disp_rob_id = '0;
  logic        disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
  logic [31:0] disp_rs1_val = '0, disp_rs2_val = '0;
  logic [3:0]  disp_rs1_tag = '0, disp_rs2_tag = '0;
  logic        rs_full;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        alu_valid;
  logic        alu_ready = 1'b0;
  logic [5:0]  alu_op;
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
  logic [3:0]  alu_rob_id;

  rs_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_rob_id(disp_rob_id), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val),
    .disp_rs2_tag(disp_rs2_tag), .rs_full(rs_full), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_pc(alu_pc), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_imm(alu_imm), .alu_rob_id(alu_rob_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: plain array of held ops; age is a global dispatch sequence number.
  typedef struct {
    bit          v;
    bit [5:0]    op;
    bit [31:0]   pc, imm;
    bit [3:0]    rob;
    bit          r1, r2;
    bit [31:0]   v1, v2;
    bit [3:0]    t1, t2;
    int unsigned seq;
  } ment_t;

  ment_t       m [DEPTH];
  bit          mav;
  bit [5:0]    mop;
  bit [31:0]   mpc, mimm, mrs1, mrs2;
  bit [3:0]    mrob;
  int unsigned mseq;

  function automatic void model_reset();
    foreach (m[i]) m[i] = '{default: 0};
    mav = 0; mop = 0; mpc = 0; mimm = 0; mrs1 = 0; mrs2 = 0; mrob = 0;
  endfunction

  function automatic int model_count();
    int n = 0;
    foreach (m[i]) if (m[i].v) n++;
    return n;
  endfunction

  function automatic void model_step();
    ment_t o [DEPTH];
    int pick, slot, held;
    if (!rdy) return;
    if (flush) begin
      foreach (m[i]) m[i].v = 0;
      mav = 0;
      return;
    end
    o = m;
    held = model_count();
    if (!mav || alu_ready) begin
      pick = -1;
      foreach (o[i]) begin
        if (o[i].v && o[i].r1 && o[i].r2) begin
`ifdef AGE_SELECT_EN
          if (pick < 0 || o[i].seq < o[pick].seq) pick = i;
`else
          if (pick < 0) pick = i;
`endif
        end
      end
      mav = (pick >= 0);
      if (pick >= 0) begin
        mop = o[pick].op; mpc = o[pick].pc; mimm = o[pick].imm; mrob = o[pick].rob;
        mrs1 = o[pick].v1; mrs2 = o[pick].v2;
        m[pick].v = 0;
      end
    end
    if (cdb_valid) begin
      foreach (m[i]) begin
        if (m[i].v && !m[i].r1 && m[i].t1 == cdb_tag) begin m[i].r1 = 1; m[i].v1 = cdb_value; end
        if (m[i].v && !m[i].r2 && m[i].t2 == cdb_tag) begin m[i].r2 = 1; m[i].v2 = cdb_value; end
      end
    end
    if (disp_valid && held < DEPTH) begin
      slot = -1;
      foreach (o[i]) if (!o[i].v && slot < 0) slot = i;
      m[slot].v = 1; m[slot].op = disp_op; m[slot].pc = disp_pc; m[slot].imm = disp_imm;
      m[slot].rob = disp_rob_id; m[slot].t1 = disp_rs1_tag; m[slot].t2 = disp_rs2_tag;
      m[slot].r1 = disp_rs1_rdy; m[slot].v1 = disp_rs1_val;
      m[slot].r2 = disp_rs2_rdy; m[slot].v2 = disp_rs2_val;
      if (!disp_rs1_rdy && cdb_valid && cdb_tag == disp_rs1_tag) begin
        m[slot].r1 = 1; m[slot].v1 = cdb_value;
      end
      if (!disp_rs2_rdy && cdb_valid && cdb_tag == disp_rs2_tag) begin
        m[slot].r2 = 1; m[slot].v2 = cdb_value;
      end
      m[slot].seq = mseq;
      mseq++;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_alu_valid", 32'(alu_valid), 32'(mav));
    chk("m_alu_op", 32'(alu_op), 32'(mop));
    chk("m_alu_pc", alu_pc, mpc);
    chk("m_alu_imm", alu_imm, mimm);
    chk("m_alu_rs1", alu_rs1, mrs1);
    chk("m_alu_rs2", alu_rs2, mrs2);
    chk("m_alu_rob", 32'(alu_rob_id), 32'(mrob));
    chk("m_rs_full", 32'(rs_full), 32'(model_count() == DEPTH));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_rs_full", 32'(rs_full), 32'd0);
    check_model();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic idle();
    disp_valid = 0; cdb_valid = 0; flush = 0; rdy = 1;
  endtask

  task automatic disp(input logic [3:0] rob, input logic r1, input logic [31:0] v1,
                      input logic [3:0] t1, input logic r2, input logic [31:0] v2);
    disp_valid = 1; disp_rob_id = rob; disp_op = 6'(rob) + 6'd1;
    disp_pc = 32'(rob) * 4; disp_imm = 32'(rob) + 100;
    disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = 4'hF;
  endtask

  typedef struct {
    bit        dv;
    bit [3:0]  rob;
    bit        r1;
    bit [31:0] v1;
    bit [3:0]  t1;
    bit        r2;
    bit [31:0] v2;
    bit        cv;
    bit [3:0]  ct;
    bit [31:0] cval;
    bit        ar;
    bit        ev;
    bit [31:0] e1, e2;
    bit [3:0]  erob;
  } vec_t;

  vec_t vt [10];
  bit [3:0] first_rob, second_rob;

  initial begin
    vt[0] = '{1, 3, 1, 5, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 7, 3};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vt[3] = '{1, 4, 0, 0, 9, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0};
    vt[4] = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 'h1234, 1, 0, 0, 0, 0};
    vt[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h1234, 2, 4};
    vt[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vt[7] = '{1, 5, 0, 0, 9, 1, 2, 1, 9, 'h1234, 1, 0, 0, 0, 0};
    vt[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h1234, 2, 5};
    vt[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    mseq = 0;
    do_reset();

    // Basic issue, wakeup and dispatch-cycle bypass.
    foreach (vt[k]) begin
      idle();
      if (vt[k].dv) disp(vt[k].rob, vt[k].r1, vt[k].v1, vt[k].t1, vt[k].r2, vt[k].v2);
      cdb_valid = vt[k].cv; cdb_tag = vt[k].ct; cdb_value = vt[k].cval;
      alu_ready = vt[k].ar;
      step();
      chk($sformatf("vec%0d_valid", k), 32'(alu_valid), 32'(vt[k].ev));
      if (vt[k].ev) begin
        chk($sformatf("vec%0d_rs1", k), alu_rs1, vt[k].e1);
        chk($sformatf("vec%0d_rs2", k), alu_rs2, vt[k].e2);
        chk($sformatf("vec%0d_rob", k), 32'(alu_rob_id), 32'(vt[k].erob));
      end
    end

    // Reset with live entries.
    for (int i = 0; i < 5; i++) begin
      idle(); disp(4'(i), 0, 0, 4'hE, 1, 1); alu_ready = 1;
      step();
    end
    idle();
    do_reset();
    step();

    // Fill to full with waiting operands, drop the overflow dispatch, free one slot.
    alu_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idle(); disp(4'(i), 0, 0, 4'(i), 1, 32'(i));
      step();
    end
    chk("full_after_fill", 32'(rs_full), 32'd1);
    idle(); disp(4'd7, 1, 1, 0, 1, 1);
    step();
    chk("full_after_drop", 32'(rs_full), 32'd1);
    idle(); cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'hABCD;
    step();
    chk("woken_not_issued", 32'(alu_valid), 32'd0);
    idle();
    step();
    chk("issue_after_wake", 32'(alu_valid), 32'd1);
    chk("issue_rob3", 32'(alu_rob_id), 32'd3);
    chk("not_full_after_free", 32'(rs_full), 32'd0);

    // Stall: outputs hold while another op becomes eligible.
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) begin cdb_valid = 1; cdb_tag = 4'd5; cdb_value = 32'h5555; end
      step();
      chk($sformatf("hold%0d_rob", c), 32'(alu_rob_id), 32'd3);
      chk($sformatf("hold%0d_rs1", c), alu_rs1, 32'hABCD);
      chk($sformatf("hold%0d_valid", c), 32'(alu_valid), 32'd1);
    end
    idle(); flush = 1; disp(4'd2, 1, 1, 0, 1, 1);
    step();
    chk("flush_valid", 32'(alu_valid), 32'd0);
    idle(); alu_ready = 1;
    step();
    chk("post_flush_valid", 32'(alu_valid), 32'd0);
    chk("post_flush_full", 32'(rs_full), 32'd0);

    // Select order: A lands in slot 1, B in slot 0 while the issue register is stalled.
    alu_ready = 0;
    idle(); disp(4'd1, 1, 32'h11, 0, 1, 32'h12); step();
    idle(); disp(4'd10, 1, 32'hA1, 0, 1, 32'hA2); step();
    idle(); disp(4'd11, 1, 32'hB1, 0, 1, 32'hB2); step();
    chk("sel_held_rob", 32'(alu_rob_id), 32'd1);
`ifdef AGE_SELECT_EN
    first_rob = 4'd10; second_rob = 4'd11;
`else
    first_rob = 4'd11; second_rob = 4'd10;
`endif
    idle(); alu_ready = 1;
    step();
    chk("sel_first", 32'(alu_rob_id), 32'(first_rob));
    step();
    chk("sel_second", 32'(alu_rob_id), 32'(second_rob));
    step();
    chk("sel_drained", 32'(alu_valid), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(499) == 0) begin
        idle();
        do_reset();
      end
      rdy = ($urandom_range(9) != 0);
      flush = ($urandom_range(49) == 0);
      disp_valid = $urandom_range(1);
      disp_op = 6'($urandom); disp_pc = $urandom; disp_imm = $urandom;
      disp_rob_id = 4'($urandom);
      disp_rs1_rdy = $urandom_range(1); disp_rs1_val = $urandom; disp_rs1_tag = 4'($urandom);
      disp_rs2_rdy = $urandom_range(1); disp_rs2_val = $urandom; disp_rs2_tag = 4'($urandom);
      cdb_valid = ($urandom_range(9) < 4); cdb_tag = 4'($urandom); cdb_value = $urandom;
      alu_ready = ($urandom_range(9) < 6);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
